// File: rtl/rx_symbol_lock.sv
// Receive-side symbol aligner: hunts for COM, locks after repeated aligned COMs, forwards aligned bytes.
// Optional RX_COM_STRIP_EN: COM bytes seen while LOCKED are consumed and not forwarded.
module rx_symbol_lock #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned LOCK_COMS = 2,
    parameter int unsigned MAX_GAP   = 16
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       data,
    input  logic       DK,
    output logic [7:0] out,
    output logic       out_DK,
    output logic       out_k,
    output logic       locked,
    output logic       lock_err
);

    localparam int unsigned CW = (LOCK_COMS < 1) ? 1 : $clog2(LOCK_COMS + 1);
    localparam int unsigned GW = $clog2(MAX_GAP + 1);
    localparam logic [CW-1:0] COM_LAST = CW'(LOCK_COMS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MAX_GAP - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] com_cnt_q, com_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    out_q, out_d;
    logic          out_dk_q, out_dk_d;
    logic          out_k_q, out_k_d;
    logic          lock_err_q, lock_err_d;

    logic [7:0] cand;
    logic       is_com;
    logic       byte_done;
    logic       gap_full;

    assign cand      = {sr_q[6:0], data};
    assign is_com    = (cand == COM);
    assign byte_done = DK && (state_q != HUNT) && (bit_cnt_q == 3'd7);
    assign gap_full  = !is_com && (gap_cnt_q == GAP_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (DK) begin
            case (state_q)
                HUNT: begin
                    if (is_com) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (byte_done) begin
                        if (is_com && (com_cnt_q == COM_LAST)) begin
                            state_d = LOCKED;
                        end else if (gap_full) begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (byte_done && gap_full) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Shift register and alignment counters; everything holds while DK is low
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (DK) begin
            sr_d = cand;
            if (state_q == HUNT || state_d == HUNT) begin
                bit_cnt_d = '0;
                com_cnt_d = '0;
                gap_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_done) begin
                    if (is_com) begin
                        gap_cnt_d = '0;
                        if (state_q == CHECK) begin
                            com_cnt_d = com_cnt_q + CW'(1);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
            end
        end
    end

    // Output logic: bytes leave only from LOCKED; the loss-causing byte is still emitted
    always_comb begin
        out_d      = out_q;
        out_dk_d   = 1'b0;
        out_k_d    = out_k_q;
        lock_err_d = 1'b0;
        if (state_q == LOCKED && byte_done) begin
`ifdef RX_COM_STRIP_EN
            if (!is_com) begin
                out_d    = cand;
                out_dk_d = 1'b1;
            end
            out_k_d = 1'b0;
`else
            out_d    = cand;
            out_dk_d = 1'b1;
            out_k_d  = is_com;
`endif
            lock_err_d = gap_full;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            out_q      <= '0;
            out_dk_q   <= 1'b0;
            out_k_q    <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            out_q      <= out_d;
            out_dk_q   <= out_dk_d;
            out_k_q    <= out_k_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign out      = out_q;
    assign out_DK   = out_dk_q;
    assign out_k    = out_k_q;
    assign locked   = (state_q == LOCKED);
    assign lock_err = lock_err_q;

endmodule

// File: tb/tb_rx_symbol_lock.sv
// Bench for rx_symbol_lock: bit-history model checked every cycle plus directed literal checks.
// Honours RX_COM_STRIP_EN the same way as the design.
module tb_rx_symbol_lock;

    localparam logic [7:0]  COM       = 8'hBC;
    localparam int          LOCK_COMS = 2;
    localparam int          MAX_GAP   = 16;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       data = 1'b0;
    logic       DK = 1'b0;
    logic [7:0] out;
    logic       out_DK, out_k, locked, lock_err;

    int vectors = 0;
    int miscompares = 0;
    int n_dk = 0;
    int n_err = 0;

    rx_symbol_lock #(.COM(COM), .LOCK_COMS(LOCK_COMS), .MAX_GAP(MAX_GAP)) dut (
        .clk(clk), .reset_L(reset_L), .data(data), .DK(DK),
        .out(out), .out_DK(out_DK), .out_k(out_k), .locked(locked), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remembers the last 8 sampled bits and how many bits have passed since
    // the COM hit that established alignment; bytes end every 8th bit after it.
    logic [7:0] m_win = '0;
    logic       m_aligned = 1'b0;
    logic       m_locked = 1'b0;
    int         m_since = 0;
    int         m_coms = 0;
    int         m_gap = 0;
    logic [7:0] e_out = '0;
    logic       e_dk = 1'b0;
    logic       e_k = 1'b0;
    logic       e_err = 1'b0;

    always @(posedge clk) begin
        logic [7:0] c;
        e_dk  = 1'b0;
        e_err = 1'b0;
        if (!reset_L) begin
            m_win = '0; m_aligned = 1'b0; m_locked = 1'b0;
            m_since = 0; m_coms = 0; m_gap = 0;
            e_out = '0; e_k = 1'b0;
        end else if (DK) begin
            c = {m_win[6:0], data};
            m_win = c;
            if (!m_aligned) begin
                if (c == COM) begin
                    m_aligned = 1'b1; m_since = 0; m_coms = 0; m_gap = 0;
                end
            end else begin
                m_since++;
                if (m_since % 8 == 0) begin
                    m_gap = (c == COM) ? 0 : m_gap + 1;
                    if (m_locked) begin
`ifdef RX_COM_STRIP_EN
                        if (c != COM) begin e_out = c; e_dk = 1'b1; end
                        e_k = 1'b0;
`else
                        e_out = c; e_dk = 1'b1; e_k = (c == COM);
`endif
                        if (m_gap == MAX_GAP) begin
                            m_locked = 1'b0; m_aligned = 1'b0; e_err = 1'b1;
                        end
                    end else if (c == COM) begin
                        m_coms++;
                        if (m_coms == LOCK_COMS) m_locked = 1'b1;
                    end else if (m_gap == MAX_GAP) begin
                        m_aligned = 1'b0;
                    end
                end
            end
        end
        #1;
        chk("out", 32'(out), 32'(e_out));
        chk("out_DK", 32'(out_DK), 32'(e_dk));
        if (e_dk) chk("out_k", 32'(out_k), 32'(e_k));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("lock_err", 32'(lock_err), 32'(e_err));
        if (out_DK === 1'b1) n_dk++;
        if (lock_err === 1'b1) n_err++;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        data = b;
        DK   = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            DK = 1'b0;
        end
    endtask

    task automatic after_edge;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_dk, base_err;
        logic [7:0] a7;
        a7 = 8'hA7;

        // Reset held with activity on the inputs
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            data = i[0];
            DK   = 1'b1;
        end
        after_edge();
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_dk", 32'(out_DK), 32'h0);
        @(negedge clk);
        reset_L = 1'b1;
        DK      = 1'b0;
        data    = 1'b0;

        // Alignment: junk bits then three COMs
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        send_byte(COM);
        send_byte(COM);
        after_edge();
        chk("align_2nd_com_locked", 32'(locked), 32'h0);
        send_byte(COM);
        after_edge();
        chk("align_3rd_com_locked", 32'(locked), 32'h1);
        chk("align_3rd_com_no_dk", 32'(out_DK), 32'h0);
        send_byte(8'h5A);
        after_edge();
        chk("first_byte_out", 32'(out), 32'h5A);
        chk("first_byte_dk", 32'(out_DK), 32'h1);
        chk("first_byte_k", 32'(out_k), 32'h0);

        // DK gap inside a byte
        for (int i = 7; i >= 4; i--) send_bit(a7[i]);
        idle(5);
        for (int i = 3; i >= 0; i--) send_bit(a7[i]);
        after_edge();
        chk("gap_out", 32'(out), 32'hA7);
        chk("gap_dk", 32'(out_DK), 32'h1);
        idle(1);
        after_edge();
        chk("gap_dk_single", 32'(out_DK), 32'h0);

        // COM forwarding or stripping while locked
        send_byte(COM);
        after_edge();
`ifdef RX_COM_STRIP_EN
        chk("com_strip_dk", 32'(out_DK), 32'h0);
        chk("com_strip_out", 32'(out), 32'hA7);
`else
        chk("com_fwd_dk", 32'(out_DK), 32'h1);
        chk("com_fwd_out", 32'(out), 32'hBC);
        chk("com_fwd_k", 32'(out_k), 32'h1);
`endif
        send_byte(8'h33);
        after_edge();
        chk("after_com_out", 32'(out), 32'h33);
        chk("after_com_dk", 32'(out_DK), 32'h1);
        chk("after_com_k", 32'(out_k), 32'h0);

        // Loss of lock after MAX_GAP non-COM bytes
        send_byte(COM);
        after_edge();
        base_dk = n_dk;
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        after_edge();
        chk("loss_14_locked", 32'(locked), 32'h1);
        send_byte(8'h0F);
        after_edge();
        chk("loss_locked", 32'(locked), 32'h0);
        chk("loss_err", 32'(lock_err), 32'h1);
        chk("loss_out", 32'(out), 32'h0F);
        chk("loss_count", 32'(n_dk - base_dk), 32'd16);
        send_byte(8'h10);
        after_edge();
        chk("loss_err_single", 32'(lock_err), 32'h0);
        chk("loss_no_emit", 32'(n_dk - base_dk), 32'd16);

        // CHECK abort: one COM, then MAX_GAP non-COM bytes
        base_dk  = n_dk;
        base_err = n_err;
        send_byte(COM);
        for (int i = 0; i < 16; i++) send_byte(8'h00);
        after_edge();
        chk("abort_locked", 32'(locked), 32'h0);
        chk("abort_dk", 32'(n_dk - base_dk), 32'd0);
        chk("abort_err", 32'(n_err - base_err), 32'd0);
        send_byte(COM); send_byte(COM); send_byte(COM);
        after_edge();
        chk("relock_locked", 32'(locked), 32'h1);

        // Asynchronous reset mid-byte while locked
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        reset_L = 1'b0;
        DK      = 1'b0;
        #1;
        chk("midrst_locked", 32'(locked), 32'h0);
        chk("midrst_out", 32'(out), 32'h00);
        idle(2);
        @(negedge clk);
        reset_L = 1'b1;
        base_dk = n_dk;
        send_byte(8'h5A); send_byte(8'h5A);
        after_edge();
        chk("postrst_no_dk", 32'(n_dk - base_dk), 32'd0);
        chk("postrst_locked", 32'(locked), 32'h0);
        send_byte(COM); send_byte(COM); send_byte(COM);
        send_byte(8'h42);
        after_edge();
        chk("postrst_out", 32'(out), 32'h42);
        chk("postrst_dk", 32'(out_DK), 32'h1);
        idle(3);
        after_edge();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
